// File: rtl/avg_seq_ctrl.sv
// avg_seq_ctrl: captures DEPTH samples into a buffer, then streams the rounded
// averages of sample pairs that are eff_lag entries apart, one result per cycle
// under a valid/ready handshake on the output.
module avg_seq_ctrl #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   lag,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDone} state_e;

    state_e        state_q;
    logic [AW-1:0] wr_ptr_q;
    // One bit wider than an address so it can reach N without wrapping.
    logic [AW:0]   rd_idx_q;
    logic [3:0]    eff_lag_q;

    // Sample storage; never reset, every run fully rewrites it before reading.
    logic [W-1:0]  buf_mem [DEPTH];

    logic [AW:0]   n_results;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [W:0]    pair_sum;
    logic [W-1:0]  pair_avg;
    logic          in_fire;
    logic          out_fire;
    logic          more_results;
    logic          load_out;
    logic          last_write;

    // Pair addressing, rounded average and handshake decode.
    always_comb begin
        n_results    = (AW+1)'(DEPTH) - (AW+1)'(eff_lag_q);
        rd_addr_a    = rd_idx_q[AW-1:0];
        // j + eff_lag never exceeds DEPTH-1 for j < N, so no wrap occurs.
        rd_addr_b    = rd_addr_a + AW'(eff_lag_q);
        // One extra bit keeps the carry so full-scale inputs round correctly.
        pair_sum     = {1'b0, buf_mem[rd_addr_a]} + {1'b0, buf_mem[rd_addr_b]}
                       + (W+1)'(1);
        pair_avg     = W'(pair_sum >> 1);
        in_fire      = in_valid && in_ready;
        out_fire     = out_valid && out_ready;
        more_results = (rd_idx_q != n_results);
        // Output register refills when empty or being drained this cycle.
        load_out     = (!out_valid || out_ready) && more_results;
        last_write   = (wr_ptr_q == AW'(DEPTH - 1));
    end

    // Buffer write port: only handshaked samples are stored.
    always_ff @(posedge clk) begin
        if (!reset && in_fire) begin
            buf_mem[wr_ptr_q] <= in_data;
        end
    end

    // Control FSM with all outputs registered; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_idx_q  <= '0;
            eff_lag_q <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        // A zero lag would pair a sample with itself; use 1.
                        eff_lag_q <= (lag == 4'd0) ? 4'd1 : lag;
                        wr_ptr_q  <= '0;
                        rd_idx_q  <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        state_q   <= StLoad;
                    end
                end

                StLoad: begin
                    if (in_fire) begin
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        if (last_write) begin
                            in_ready <= 1'b0;
                            state_q  <= StCalc;
                        end
                    end
                end

                StCalc: begin
                    if (out_fire && !more_results) begin
                        // Final result accepted: nothing left to present.
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end else if (load_out) begin
                        out_data  <= pair_avg;
                        out_valid <= 1'b1;
                        rd_idx_q  <= rd_idx_q + (AW+1)'(1);
                    end
                end

                StDone: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avg_seq_ctrl.sv
// Directed bench for avg_seq_ctrl: ramp, rounding, lag handling, backpressure,
// input gaps and mid-run reset, each with hand-computed expected results.
module tb_avg_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] lag;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [7:0] samp [128];
    logic [7:0] res [$];
    int         done_pulses;
    int         stall_bad;
    bit         stall_done;
    bit         timed_out;

    avg_seq_ctrl #(.DEPTH(128), .W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .lag       (lag),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; start is seen by the next posedge.
    task automatic start_run(input logic [3:0] l);
        start = 1'b1;
        lag   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers samp[0..count-1]; counts cycles where in_ready was not high.
    task automatic load_samples(input int max_gap, input int count, output int ready_bad);
        ready_bad = 0;
        for (int i = 0; i < count; i++) begin
            if (max_gap > 0) begin
                in_valid = 1'b0;
                in_data  = 8'hEE;
                repeat ($urandom_range(0, max_gap)) @(negedge clk);
            end
            if (in_ready !== 1'b1) ready_bad++;
            in_valid = 1'b1;
            in_data  = samp[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'hEE;
    endtask

    // mode 0: out_ready=1; mode 1: random. Optional 10-cycle stall after
    // stall_at results; optional early return after stop_after results.
    task automatic collect(input int mode, input int stall_at, input int stop_after);
        int         cycles;
        logic [7:0] held;
        cycles      = 0;
        res.delete();
        done_pulses = 0;
        stall_bad   = 0;
        stall_done  = 0;
        timed_out   = 0;
        while (1) begin
            if (cycles >= 3000) begin
                timed_out = 1;
                break;
            end
            if (done === 1'b1) begin
                done_pulses++;
                break;
            end
            if (stall_at >= 0 && !stall_done && res.size() == stall_at && out_valid === 1'b1) begin
                stall_done = 1;
                held       = out_data;
                out_ready  = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    cycles++;
                    if (out_valid !== 1'b1 || out_data !== held) stall_bad++;
                end
            end
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (out_valid === 1'b1 && out_ready === 1'b1) res.push_back(out_data);
            if (stop_after > 0 && res.size() == stop_after) break;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; lag = 4'd0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        int rb;
        for (int i = 0; i < 128; i++) samp[i] = 8'(i);
        start_run(4'd8);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy: got %b want 1", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ramp_in_ready_load: got %b want 1", in_ready); end
        load_samples(0, 128, rb);
        checks++; if (rb != 0) begin errors++; $display("FAIL ramp_ready_during_load: got %0d low cycles want 0", rb); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ramp_in_ready_calc: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ramp_first_latency: got out_valid %b want 0", out_valid); end
        collect(0, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL ramp_timeout: got timeout want done"); end
        checks++; if (res.size() != 120) begin errors++; $display("FAIL ramp_count: got %0d want 120", res.size()); end
        for (int j = 0; j < res.size() && j < 120; j++) begin
            checks++;
            if (res[j] !== 8'(j + 4)) begin errors++; $display("FAIL ramp_result[%0d]: got %0d want %0d", j, res[j], j + 4); end
        end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL ramp_done_seen: got %0d want 1", done_pulses); end
        // start during the DONE cycle must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ramp_done_width: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_idle_busy: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ramp_start_in_done: got busy=%b in_ready=%b want 0 0", busy, in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_rounding();
        int rb;
        // Alternating 0,1 with lag 1: every pair sums to 1, rounds up to 1.
        for (int i = 0; i < 128; i++) samp[i] = 8'(i % 2);
        start_run(4'd1);
        load_samples(0, 128, rb);
        collect(0, -1, 0);
        checks++; if (res.size() != 127) begin errors++; $display("FAIL round_alt_count: got %0d want 127", res.size()); end
        for (int j = 0; j < res.size(); j++) begin
            checks++;
            if (res[j] !== 8'd1) begin errors++; $display("FAIL round_alt[%0d]: got %0d want 1", j, res[j]); end
        end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL round_alt_done: got %0d want 1", done_pulses); end
        repeat (2) @(negedge clk);
        // Full scale: 255+255+1 must not overflow.
        for (int i = 0; i < 128; i++) samp[i] = 8'd255;
        start_run(4'd3);
        load_samples(0, 128, rb);
        collect(0, -1, 0);
        checks++; if (res.size() != 125) begin errors++; $display("FAIL round_max_count: got %0d want 125", res.size()); end
        for (int j = 0; j < res.size(); j++) begin
            checks++;
            if (res[j] !== 8'd255) begin errors++; $display("FAIL round_max[%0d]: got %0d want 255", j, res[j]); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lag_zero();
        int rb;
        // samp = 2i, eff lag 1: (2j + 2j+2 + 1) >> 1 = 2j+1.
        for (int i = 0; i < 128; i++) samp[i] = 8'(2 * i);
        start_run(4'd0);
        lag = 4'd9;
        load_samples(0, 128, rb);
        lag = 4'd2;
        collect(0, -1, 0);
        checks++; if (res.size() != 127) begin errors++; $display("FAIL lag0_count: got %0d want 127", res.size()); end
        for (int j = 0; j < res.size(); j++) begin
            checks++;
            if (res[j] !== 8'(2 * j + 1)) begin errors++; $display("FAIL lag0_result[%0d]: got %0d want %0d", j, res[j], 2 * j + 1); end
        end
        lag = 4'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        int rb;
        // samp = 255-i, lag 5: (506 - 2j) >> 1 = 253 - j, 123 results.
        for (int i = 0; i < 128; i++) samp[i] = 8'(255 - i);
        start_run(4'd5);
        load_samples(0, 128, rb);
        collect(1, 20, 0);
        checks++; if (!stall_done) begin errors++; $display("FAIL bp_stall_reached: got 0 want 1"); end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d bad cycles want 0", stall_bad); end
        checks++; if (res.size() != 123) begin errors++; $display("FAIL bp_count: got %0d want 123", res.size()); end
        for (int j = 0; j < res.size() && j < 123; j++) begin
            checks++;
            if (res[j] !== 8'(253 - j)) begin errors++; $display("FAIL bp_result[%0d]: got %0d want %0d", j, res[j], 253 - j); end
        end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_pulses); end
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_gaps();
        int rb;
        // samp = 127-i, lag 2: (253 - 2j) >> 1 = 126 - j, 126 results.
        for (int i = 0; i < 128; i++) samp[i] = 8'(127 - i);
        start_run(4'd2);
        load_samples(3, 127, rb);
        checks++; if (rb != 0) begin errors++; $display("FAIL gap_ready_during_load: got %0d low cycles want 0", rb); end
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL gap_early_calc: got in_ready %b want 1", in_ready); end
        in_valid = 1'b1;
        in_data  = samp[127];
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL gap_calc_entry: got in_ready %b want 0", in_ready); end
        collect(0, -1, 0);
        checks++; if (res.size() != 126) begin errors++; $display("FAIL gap_count: got %0d want 126", res.size()); end
        for (int j = 0; j < res.size(); j++) begin
            checks++;
            if (res[j] !== 8'(126 - j)) begin errors++; $display("FAIL gap_result[%0d]: got %0d want %0d", j, res[j], 126 - j); end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int rb;
        for (int i = 0; i < 128; i++) samp[i] = 8'(i);
        start_run(4'd8);
        load_samples(0, 60, rb);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_load_idle: got in_ready=%b busy=%b want 0 0", in_ready, busy); end
        checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_load_out: got out_valid=%b done=%b want 0 0", out_valid, done); end
        start_run(4'd8);
        load_samples(0, 128, rb);
        collect(0, -1, 50);
        checks++; if (res.size() != 50) begin errors++; $display("FAIL rst_calc_reach: got %0d results want 50", res.size()); end
        // Reset lands on the same edge as a handshake and must win.
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_calc_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_calc_out_data: got %0d want 0", out_data); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_calc_idle: got busy=%b in_ready=%b want 0 0", busy, in_ready); end
        @(negedge clk);
        // Fresh run, lag 15: (2j + 15 + 1) >> 1 = j + 8, 113 results.
        start_run(4'd15);
        load_samples(0, 128, rb);
        collect(0, -1, 0);
        checks++; if (res.size() != 113) begin errors++; $display("FAIL rst_rerun_count: got %0d want 113", res.size()); end
        for (int j = 0; j < res.size(); j++) begin
            checks++;
            if (res[j] !== 8'(j + 8)) begin errors++; $display("FAIL rst_rerun[%0d]: got %0d want %0d", j, res[j], j + 8); end
        end
        checks++; if (done_pulses != 1) begin errors++; $display("FAIL rst_rerun_done: got %0d want 1", done_pulses); end
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_rounding();
        test_lag_zero();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avg_seq_ctrl.md
AVG_SEQ_CTRL -- requirements
Module: avg_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 128, which sets the number of sample-buffer entries (power of two).
REQ-002 SHALL have parameter W, default 8, which sets the sample and result width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: requests one capture/compute run; honoured only in IDLE.
REQ-006 SHALL have port lag, input, 4 bits: pair distance, sampled on the cycle start is accepted.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 SHALL have port in_data, input, W bits: the incoming sample.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-011 SHALL have port out_data, output, W bits: the rounded pair average.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at run completion.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CALC and DONE.
REQ-016 IDLE: start=1 SHALL latch eff_lag, clear wr_ptr and rd_idx, and go to LOAD next cycle; eff_lag = lag, except lag=0 gives eff_lag=1.
REQ-017 start SHALL be ignored in LOAD, CALC and DONE; the latched eff_lag SHALL be unchanged by lag input changes during a run.
REQ-018 LOAD: in_ready=1; each cycle with in_valid&in_ready SHALL write in_data to buf[wr_ptr] and increment wr_ptr; cycles with in_valid=0 SHALL leave wr_ptr unchanged.
REQ-019 The write of entry DEPTH-1 SHALL move the FSM to CALC on the same edge; in_ready SHALL be 0 from the next cycle.
REQ-020 CALC SHALL produce N = DEPTH - eff_lag results in index order j = 0..N-1.
REQ-021 Each result SHALL be out_data = (buf[j] + buf[j+eff_lag] + 1) >> 1, computed in W+1 bits with no overflow (255+255 gives 255).
REQ-022 out_valid and out_data SHALL be registered; the first result SHALL appear on the first edge after entry to CALC.
REQ-023 The output register SHALL load the next result when empty or when out_valid&out_ready, giving 1 result per cycle while out_ready=1.
REQ-024 While out_valid=1 and out_ready=0, out_data SHALL hold stable and rd_idx SHALL not advance.
REQ-025 Acceptance of result N-1 SHALL clear out_valid and go to DONE; DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-026 Outside CALC, out_valid SHALL be 0; outside LOAD, in_ready SHALL be 0.
REQ-027 start=1 in the DONE cycle SHALL be ignored; a new run requires start while in IDLE.

Reset
REQ-028 reset=1 at any clock edge, including mid-LOAD or mid-CALC, SHALL force IDLE and clear wr_ptr, rd_idx and eff_lag.
REQ-029 reset SHALL also set in_ready=0, out_valid=0, out_data=0, busy=0 and done=0 on the next edge.
REQ-030 Buffer contents need not be cleared; a run always fully reloads the buffer before reading it.
REQ-031 reset SHALL take priority over start and all handshakes in the same cycle.

Verification
REQ-032 Ramp, lag=8: in_data = k for k = 0..127, out_ready=1 -> 120 results, result k = k+4, then a single done pulse.
REQ-033 Rounding: alternating 0,1 samples, lag=1 -> 127 results all equal to 1; all samples 255, lag=3 -> 125 results of 255.
REQ-034 lag=0 -> treated as lag 1, 127 results; changing lag mid-run has no effect on results.
REQ-035 Backpressure: out_ready toggled randomly plus a 10-cycle stall -> out_data stable during the stall, no result lost or duplicated, count = N.
REQ-036 Gaps in in_valid -> only handshaked samples are stored; CALC is entered only after the 128th accepted sample.
REQ-037 Reset at sample 60 of LOAD and at result 50 of CALC -> outputs zero next cycle, FSM in IDLE, and a following run with start gives fully correct results.
